// File: rtl/scan_ctrl_regs.sv
// Register responder for the scan register path: 17-bit control register, 15-bit status register,
// fixed-latency access handshake. Optional interrupt output is enabled by defining SCAN_CTRL_IRQ_EN.
module scan_ctrl_regs #(
    parameter int unsigned ACCESS_LAT = 2,
    parameter logic [16:0] CR_RST_VAL = 17'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reg_wen,
    input  logic        reg_ren,
    input  logic [16:0] cr_wdata,
    output logic [16:0] cr_rdata,
    output logic [14:0] sr_rdata,
    output logic        reg_ready,
    input  logic        core_busy,
    input  logic        core_done,
    input  logic        core_err,
    output logic        ctrl_enable,
    output logic        ctrl_start,
    output logic [3:0]  ctrl_mode,
    output logic [9:0]  ctrl_cfg,
    output logic        irq
);

    // Start and clr_status are write-one strobes and are never stored.
    localparam logic [16:0] CrRst   = CR_RST_VAL & ~17'h00006;
    localparam logic [3:0]  LatInit = 4'(ACCESS_LAT - 1);

    typedef enum logic [1:0] {StIdle, StWait, StReady, StHold} state_e;

    state_e      state_q, state_d;
    logic [3:0]  lat_q, lat_d;
    logic [16:0] cr_q, cr_d;
    logic [16:0] cr_rdata_q, cr_rdata_d;
    logic [14:0] sr_rdata_q, sr_rdata_d;
    logic        busy_q;
    logic        done_sticky_q, done_sticky_d;
    logic        err_sticky_q, err_sticky_d;
    logic [11:0] done_cnt_q, done_cnt_d;
    logic        reg_ready_q, reg_ready_d;
    logic        ctrl_start_q, ctrl_start_d;

    logic        wr_accept;
    logic        start_req;
    logic        clr_req;
    logic [14:0] sr_cur;

    assign wr_accept = (state_q == StIdle) && reg_wen;
    assign start_req = wr_accept && cr_wdata[1];
    assign clr_req   = wr_accept && cr_wdata[2];
    assign sr_cur    = {done_cnt_q, err_sticky_q, done_sticky_q, busy_q};

    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        cr_d        = cr_q;
        cr_rdata_d  = cr_rdata_q;
        sr_rdata_d  = sr_rdata_q;
        reg_ready_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (reg_wen || reg_ren) begin
                    state_d = StWait;
                    lat_d   = LatInit;
                    if (reg_wen) begin
                        cr_d = {cr_wdata[16:3], 2'b00, cr_wdata[0]};
                    end
                end
            end
            StWait: begin
                if (lat_q == 4'd0) begin
                    state_d     = StReady;
                    reg_ready_d = 1'b1;
                    cr_rdata_d  = cr_q;
                    sr_rdata_d  = sr_cur;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            StReady: state_d = StHold;
            // A strobe still held from the finished access must not start another one.
            StHold: begin
                if (!reg_wen && !reg_ren) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Clear is applied first so a same-cycle event still sets its bit.
    always_comb begin
        done_sticky_d = done_sticky_q;
        err_sticky_d  = err_sticky_q;
        done_cnt_d    = done_cnt_q;
        ctrl_start_d  = start_req && !core_busy;
        if (clr_req) begin
            done_sticky_d = 1'b0;
            err_sticky_d  = 1'b0;
            done_cnt_d    = 12'h000;
        end
        if (core_done) begin
            done_sticky_d = 1'b1;
            if (done_cnt_d != 12'hFFF) begin
                done_cnt_d = done_cnt_d + 12'h001;
            end
        end
        if (core_err || (start_req && core_busy)) begin
            err_sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            lat_q         <= 4'd0;
            cr_q          <= CrRst;
            cr_rdata_q    <= CrRst;
            sr_rdata_q    <= 15'h0000;
            busy_q        <= 1'b0;
            done_sticky_q <= 1'b0;
            err_sticky_q  <= 1'b0;
            done_cnt_q    <= 12'h000;
            reg_ready_q   <= 1'b0;
            ctrl_start_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            lat_q         <= lat_d;
            cr_q          <= cr_d;
            cr_rdata_q    <= cr_rdata_d;
            sr_rdata_q    <= sr_rdata_d;
            busy_q        <= core_busy;
            done_sticky_q <= done_sticky_d;
            err_sticky_q  <= err_sticky_d;
            done_cnt_q    <= done_cnt_d;
            reg_ready_q   <= reg_ready_d;
            ctrl_start_q  <= ctrl_start_d;
        end
    end

`ifdef SCAN_CTRL_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= cr_q[0] && (done_sticky_q || err_sticky_q);
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    assign cr_rdata    = cr_rdata_q;
    assign sr_rdata    = sr_rdata_q;
    assign reg_ready   = reg_ready_q;
    assign ctrl_enable = cr_q[0];
    assign ctrl_start  = ctrl_start_q;
    assign ctrl_mode   = cr_q[6:3];
    assign ctrl_cfg    = cr_q[16:7];

endmodule
